// File: rtl/tg_14bit_checker.sv
// AXI-Stream sink that locks onto an incrementing sample sequence and keeps
// saturating beat/error counters plus a first-error capture for status readout.
module tg_14bit_checker #(
  parameter int          DATA_WIDTH    = 14,
  parameter int          CNT_WIDTH     = 32,
  parameter int          STEP          = 1,
  parameter logic [15:0] READY_PATTERN = 16'hFFFF
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  extenable,
  input  logic                  clr_stats,
  input  logic                  S_AXIS_TVALID,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  output logic                  S_AXIS_TREADY,
  output logic                  locked,
  output logic [CNT_WIDTH-1:0]  sample_count,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic                  err_sticky,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic [DATA_WIDTH-1:0] first_err_exp,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] STEP_W  = DATA_WIDTH'(STEP);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

  state_t                state_q, state_d;
  logic [15:0]           pattern_q, pattern_d;
  logic [DATA_WIDTH-1:0] expected_q, expected_d;
  logic                  locked_q, locked_d;
  logic [CNT_WIDTH-1:0]  sample_cnt_q, sample_cnt_d;
  logic [CNT_WIDTH-1:0]  error_cnt_q, error_cnt_d;
  logic                  sticky_q, sticky_d;
  logic [DATA_WIDTH-1:0] err_data_q, err_data_d;
  logic [DATA_WIDTH-1:0] err_exp_q, err_exp_d;
  logic                  xfer;
  logic                  mismatch;

  // Handshake: a beat moves on a rising edge where TVALID and TREADY are both
  // high; TREADY comes straight from state/pattern flops, never from inputs.
  assign S_AXIS_TREADY = (state_q != IDLE) & pattern_q[0];
  assign xfer          = S_AXIS_TVALID & S_AXIS_TREADY;
  assign mismatch      = (state_q == CHECK) && (S_AXIS_TDATA != expected_q);

  always_comb begin
    state_d      = state_q;
    pattern_d    = pattern_q;
    expected_d   = expected_q;
    locked_d     = locked_q;
    sample_cnt_d = sample_cnt_q;
    error_cnt_d  = error_cnt_q;
    sticky_d     = sticky_q;
    err_data_d   = err_data_q;
    err_exp_d    = err_exp_q;

    // Always resync to the received beat so one glitch costs one error.
    if (xfer) expected_d = S_AXIS_TDATA + STEP_W;

    if (clr_stats) begin
      sample_cnt_d = '0;
      error_cnt_d  = '0;
      sticky_d     = 1'b0;
      err_data_d   = '0;
      err_exp_d    = '0;
    end else if (xfer) begin
      if (sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + CNT_ONE;
      if (mismatch) begin
        if (error_cnt_q != '1) error_cnt_d = error_cnt_q + CNT_ONE;
        if (!sticky_q) begin
          sticky_d   = 1'b1;
          err_data_d = S_AXIS_TDATA;
          err_exp_d  = expected_q;
        end
      end
    end

    case (state_q)
      IDLE: begin
        pattern_d = READY_PATTERN;
        if (extenable) state_d = SYNC;
      end
      SYNC, CHECK: begin
        if (!extenable) begin
          state_d   = IDLE;
          pattern_d = READY_PATTERN;
          locked_d  = 1'b0;
        end else begin
          pattern_d = {pattern_q[0], pattern_q[15:1]};
          if (xfer) begin
            state_d  = CHECK;
            locked_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pattern_d = READY_PATTERN;
        locked_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pattern_q    <= READY_PATTERN;
      expected_q   <= '0;
      locked_q     <= 1'b0;
      sample_cnt_q <= '0;
      error_cnt_q  <= '0;
      sticky_q     <= 1'b0;
      err_data_q   <= '0;
      err_exp_q    <= '0;
    end else begin
      state_q      <= state_d;
      pattern_q    <= pattern_d;
      expected_q   <= expected_d;
      locked_q     <= locked_d;
      sample_cnt_q <= sample_cnt_d;
      error_cnt_q  <= error_cnt_d;
      sticky_q     <= sticky_d;
      err_data_q   <= err_data_d;
      err_exp_q    <= err_exp_d;
    end
  end

  assign locked         = locked_q;
  assign sample_count   = sample_cnt_q;
  assign error_count    = error_cnt_q;
  assign err_sticky     = sticky_q;
  assign first_err_data = err_data_q;
  assign first_err_exp  = err_exp_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_tg_14bit_checker.sv
// Bench for tg_14bit_checker: stream 0 uses the default all-ones throttle,
// stream 1 a 5555 throttle with 4-bit counters so saturation is reachable.
module tb_tg_14bit_checker;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en    [2];
  logic        clr   [2];
  logic        valid [2];
  logic [13:0] data  [2];

  logic        ready_a, locked_a, sticky_a;
  logic [31:0] sc_a, ec_a;
  logic [13:0] fd_a, fe_a;
  logic [1:0]  st_a;
  logic        ready_b, locked_b, sticky_b;
  logic [3:0]  sc_b, ec_b;
  logic [13:0] fd_b, fe_b;
  logic [1:0]  st_b;

  logic        o_ready [2];
  logic        o_locked[2];
  logic        o_sticky[2];
  logic [31:0] o_sc    [2];
  logic [31:0] o_ec    [2];
  logic [13:0] o_fd    [2];
  logic [13:0] o_fe    [2];
  logic [1:0]  o_st    [2];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  tg_14bit_checker dut_a (
    .aclk(clk), .resetn(rstn), .extenable(en[0]), .clr_stats(clr[0]),
    .S_AXIS_TVALID(valid[0]), .S_AXIS_TDATA(data[0]), .S_AXIS_TREADY(ready_a),
    .locked(locked_a), .sample_count(sc_a), .error_count(ec_a),
    .err_sticky(sticky_a), .first_err_data(fd_a), .first_err_exp(fe_a),
    .dbg_state(st_a)
  );

  tg_14bit_checker #(.CNT_WIDTH(4), .READY_PATTERN(16'h5555)) dut_b (
    .aclk(clk), .resetn(rstn), .extenable(en[1]), .clr_stats(clr[1]),
    .S_AXIS_TVALID(valid[1]), .S_AXIS_TDATA(data[1]), .S_AXIS_TREADY(ready_b),
    .locked(locked_b), .sample_count(sc_b), .error_count(ec_b),
    .err_sticky(sticky_b), .first_err_data(fd_b), .first_err_exp(fe_b),
    .dbg_state(st_b)
  );

  assign o_ready[0] = ready_a;  assign o_ready[1] = ready_b;
  assign o_locked[0] = locked_a; assign o_locked[1] = locked_b;
  assign o_sticky[0] = sticky_a; assign o_sticky[1] = sticky_b;
  assign o_sc[0] = sc_a;        assign o_sc[1] = {28'd0, sc_b};
  assign o_ec[0] = ec_a;        assign o_ec[1] = {28'd0, ec_b};
  assign o_fd[0] = fd_a;        assign o_fd[1] = fd_b;
  assign o_fe[0] = fe_a;        assign o_fe[1] = fe_b;
  assign o_st[0] = st_a;        assign o_st[1] = st_b;

  // Reference model: "active" = stream enabled, "phase" = cycles since enabling,
  // so the expected TREADY is simply bit (phase mod 16) of the throttle word.
  logic [15:0] pat [2];
  longint      cmax[2];
  bit          m_active[2], m_locked[2], m_sticky[2];
  int          m_phase[2], m_exp[2], m_fd[2], m_fe[2];
  longint      m_sc[2], m_ec[2];

  initial begin
    pat[0] = 16'hFFFF; pat[1] = 16'h5555;
    cmax[0] = 64'hFFFF_FFFF; cmax[1] = 15;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit rdy, tr;
      rdy = m_active[k] && pat[k][m_phase[k] % 16];
      tr  = valid[k] && rdy;
      if (!rstn) begin
        m_active[k] = 0; m_locked[k] = 0; m_sticky[k] = 0; m_phase[k] = 0;
        m_exp[k] = 0; m_fd[k] = 0; m_fe[k] = 0; m_sc[k] = 0; m_ec[k] = 0;
      end else begin
        if (clr[k]) begin
          m_sc[k] = 0; m_ec[k] = 0; m_sticky[k] = 0; m_fd[k] = 0; m_fe[k] = 0;
        end else if (tr) begin
          m_sc[k] = (m_sc[k] + 1 > cmax[k]) ? cmax[k] : m_sc[k] + 1;
          if (m_locked[k] && int'(data[k]) != m_exp[k]) begin
            m_ec[k] = (m_ec[k] + 1 > cmax[k]) ? cmax[k] : m_ec[k] + 1;
            if (!m_sticky[k]) begin
              m_sticky[k] = 1; m_fd[k] = int'(data[k]); m_fe[k] = m_exp[k];
            end
          end
        end
        if (tr) m_exp[k] = (int'(data[k]) + 1) % 16384;
        if (!m_active[k]) begin
          if (en[k]) begin m_active[k] = 1; m_phase[k] = 0; end
        end else if (!en[k]) begin
          m_active[k] = 0; m_locked[k] = 0; m_phase[k] = 0;
        end else begin
          m_phase[k] = m_phase[k] + 1;
          if (tr) m_locked[k] = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard compare on the falling edge, clear of the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        int st_exp;
        st_exp = !m_active[k] ? 0 : (m_locked[k] ? 2 : 1);
        chk($sformatf("s%0d_tready", k), o_ready[k],
            m_active[k] && pat[k][m_phase[k] % 16]);
        chk($sformatf("s%0d_locked", k), o_locked[k], m_locked[k]);
        chk($sformatf("s%0d_state", k), o_st[k], st_exp);
        chk($sformatf("s%0d_sample_count", k), o_sc[k], m_sc[k]);
        chk($sformatf("s%0d_error_count", k), o_ec[k], m_ec[k]);
        chk($sformatf("s%0d_err_sticky", k), o_sticky[k], m_sticky[k]);
        chk($sformatf("s%0d_first_err_data", k), o_fd[k], m_fd[k]);
        chk($sformatf("s%0d_first_err_exp", k), o_fe[k], m_fe[k]);
      end
    end
  end

  // Present one beat on stream k and return after the edge that accepts it.
  task automatic send(input int k, input int v, output int waits);
    waits = 0;
    valid[k] = 1'b1;
    data[k]  = v[13:0];
    while (o_ready[k] !== 1'b1 && waits < 64) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 64) chk($sformatf("s%0d_send_timeout", k), waits, 0);
    else @(negedge clk);
  endtask

  task automatic relock(input int k);
    valid[k] = 1'b0;
    en[k] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    en[k] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, stalls, xf, nxt;
    int seq2[5];
    int seq3[5];
    seq2 = '{16381, 16382, 16383, 0, 1};
    seq3 = '{10, 11, 13, 14, 15};
    rstn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      en[k] = 0; clr[k] = 0; valid[k] = 0; data[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_sample_count", sc_a, 0);
    chk("rst_tready", ready_a, 0);
    chk("rst_locked", locked_a, 0);
    rstn = 1'b1;
    cmp_en = 1'b1;

    // Test 1: 0..99 always valid, all-ones throttle
    en[0] = 1'b1;
    stalls = 0;
    for (int v = 0; v < 100; v++) begin
      send(0, v, w);
      if (v > 0) stalls += w;
    end
    valid[0] = 1'b0;
    chk("t1_stalls", stalls, 0);
    chk("t1_sample_count", sc_a, 100);
    chk("t1_error_count", ec_a, 0);
    chk("t1_locked", locked_a, 1);

    // Test 2: wrap through 3FFF -> 0000
    relock(0);
    foreach (seq2[i]) send(0, seq2[i], w);
    valid[0] = 1'b0;
    chk("t2_error_count", ec_a, 0);
    chk("t2_sample_count", sc_a, 105);

    // Test 3: one skipped sample
    relock(0);
    foreach (seq3[i]) send(0, seq3[i], w);
    valid[0] = 1'b0;
    chk("t3_error_count", ec_a, 1);
    chk("t3_first_err_data", fd_a, 13);
    chk("t3_first_err_exp", fe_a, 12);
    chk("t3_err_sticky", sticky_a, 1);

    // Test 5: drop enable mid-stream, resume at 500
    send(0, 16, w);
    send(0, 17, w);
    valid[0] = 1'b0;
    en[0] = 1'b0;
    @(negedge clk);
    chk("t5_tready_idle", ready_a, 0);
    chk("t5_locked_idle", locked_a, 0);
    repeat (3) @(negedge clk);
    en[0] = 1'b1;
    for (int v = 500; v < 503; v++) send(0, v, w);
    valid[0] = 1'b0;
    chk("t5_error_count", ec_a, 1);
    chk("t5_locked", locked_a, 1);
    chk("t5_sample_count", sc_a, 115);

    // Test 6: clear coincident with a (mismatching) transfer, then reset
    clr[0] = 1'b1;
    valid[0] = 1'b1;
    data[0] = 14'd600;
    @(negedge clk);
    clr[0] = 1'b0;
    valid[0] = 1'b0;
    chk("t6_clr_sample_count", sc_a, 0);
    chk("t6_clr_error_count", ec_a, 0);
    chk("t6_clr_sticky", sticky_a, 0);
    chk("t6_clr_first_err_data", fd_a, 0);
    send(0, 601, w);
    valid[0] = 1'b0;
    chk("t6_after_clr_count", sc_a, 1);
    chk("t6_after_clr_errors", ec_a, 0);
    valid[0] = 1'b1;
    data[0] = 14'd602;
    rstn = 1'b0;
    @(negedge clk);
    chk("t6_rst_sample_count", sc_a, 0);
    chk("t6_rst_locked", locked_a, 0);
    chk("t6_rst_tready", ready_a, 0);
    rstn = 1'b1;
    valid[0] = 1'b0;
    en[0] = 1'b0;

    // Test 4: 5555 throttle on stream 1, 32 enabled cycles
    en[1] = 1'b1;
    @(negedge clk);
    nxt = 0;
    xf = 0;
    valid[1] = 1'b1;
    repeat (32) begin
      data[1] = nxt[13:0];
      if (ready_b === 1'b1) begin
        xf++;
        nxt++;
      end
      @(negedge clk);
    end
    valid[1] = 1'b0;
    en[1] = 1'b0;
    chk("t4_transfers", xf, 16);
    chk("t4_sample_count_sat", sc_b, 15);
    chk("t4_error_count", ec_b, 0);
    repeat (2) @(negedge clk);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
